// File: rtl/pos_cell_access_ctrl.sv
// Sequencer/arbiter in front of one single-port cell position RAM.
// Address 0 holds the particle count; addresses 1..count hold {posz,posy,posx}.
module pos_cell_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_start,
    input  logic                  i_rd_abort,
    output logic                  o_rd_busy,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH-1:0] o_rd_id,
    output logic                  o_rd_done,
    output logic [ADDR_WIDTH-1:0] o_cell_count,
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_grant,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_mem_rden,
    output logic                  o_mem_wren,
    input  logic [DATA_WIDTH-1:0] i_mem_q
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CNT_RD   = 3'd1;
    localparam logic [2:0] S_CNT_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    localparam int                    WAIT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [2:0]              r_state;
    logic                    r_rd_pend;
    logic                    r_last_grant;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr_cnt;
    logic [ADDR_WIDTH-1:0]   r_cell_count;
    logic [READ_LATENCY-1:0] r_vld_pipe;
    logic [ADDR_WIDTH-1:0]   r_id_pipe [READ_LATENCY];

    logic [2:0]              w_state_next;
    logic                    w_rd_busy;
    logic                    w_rd_req;
    logic                    w_wr_grant;
    logic                    w_push;
    logic                    w_wait_last;
    logic [ADDR_WIDTH-1:0]   w_count_raw;
    logic [ADDR_WIDTH-1:0]   w_count_clamped;
    logic [READ_LATENCY-1:0] w_vld_upper;

    assign w_rd_busy   = r_rd_pend | (r_state != S_IDLE);
    // A fresh start pulse is seen by the IDLE arbiter in the same cycle.
    assign w_rd_req    = (r_rd_pend | (i_rd_start & ~w_rd_busy)) & ~i_rd_abort;
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);
    assign w_count_raw = i_mem_q[ADDR_WIDTH-1:0];
    assign w_count_clamped = (w_count_raw > MAX_COUNT) ? MAX_COUNT : w_count_raw;

    // Grant is gated by rst_n so every output reads 0 while reset is held.
    assign w_wr_grant = rst_n & (r_state == S_IDLE) & i_wr_req &
                        (~w_rd_req | (r_last_grant == GRANT_READ));

    always_comb begin
        w_vld_upper = r_vld_pipe;
        w_vld_upper[READ_LATENCY-1] = 1'b0;
    end

    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        o_mem_address = '0;
        o_mem_data    = '0;
        o_mem_rden    = 1'b0;
        o_mem_wren    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_grant) begin
                    o_mem_wren    = 1'b1;
                    o_mem_address = i_wr_addr;
                    o_mem_data    = i_wr_data;
                end else if (w_rd_req) begin
                    w_state_next = S_CNT_RD;
                end
            end
            S_CNT_RD: begin
                if (i_rd_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    o_mem_rden   = 1'b1;
                    w_state_next = S_CNT_WAIT;
                end
            end
            S_CNT_WAIT: begin
                if (i_rd_abort)
                    w_state_next = S_IDLE;
                else if (w_wait_last)
                    w_state_next = (w_count_clamped == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (i_rd_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    o_mem_rden    = 1'b1;
                    o_mem_address = r_addr_cnt;
                    w_push        = 1'b1;
                    if (r_addr_cnt == r_cell_count)
                        w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once only the output stage still holds data, so rd_done
                // lands on the cycle right after the last rd_valid.
                if (i_rd_abort)
                    w_state_next = S_IDLE;
                else if (w_vld_upper == '0)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_pend    <= 1'b0;
            r_last_grant <= GRANT_READ;
            r_wait_cnt   <= '0;
            r_addr_cnt   <= '0;
            r_cell_count <= '0;
        end else begin
            r_state <= w_state_next;

            if (i_rd_abort || (r_state == S_CNT_RD))
                r_rd_pend <= 1'b0;
            else if (i_rd_start && !w_rd_busy)
                r_rd_pend <= 1'b1;

            if (w_wr_grant)
                r_last_grant <= GRANT_WRITE;
            else if (r_state == S_CNT_RD)
                r_last_grant <= GRANT_READ;

            if (r_state == S_CNT_WAIT)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else
                r_wait_cnt <= '0;

            if ((r_state == S_CNT_WAIT) && w_wait_last && !i_rd_abort) begin
                r_cell_count <= w_count_clamped;
                r_addr_cnt   <= ADDR_WIDTH'(1);
            end else if (w_push) begin
                r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Valid/id travel alongside the RAM read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                r_id_pipe[i] <= '0;
        end else begin
            if (i_rd_abort) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_push;
                for (int i = 1; i < READ_LATENCY; i++)
                    r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
            r_id_pipe[0] <= r_addr_cnt;
            for (int i = 1; i < READ_LATENCY; i++)
                r_id_pipe[i] <= r_id_pipe[i-1];
        end
    end

    assign o_rd_busy    = w_rd_busy;
    assign o_rd_valid   = r_vld_pipe[READ_LATENCY-1];
    assign o_rd_id      = o_rd_valid ? r_id_pipe[READ_LATENCY-1] : '0;
    assign o_rd_data    = o_rd_valid ? i_mem_q : '0;
    assign o_rd_done    = (r_state == S_DONE) & ~i_rd_abort;
    assign o_cell_count = r_cell_count;
    assign o_wr_grant   = w_wr_grant;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Directed bench for pos_cell_access_ctrl with a 2-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_pos_cell_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_start, rd_abort, rd_busy, rd_valid, rd_done;
    logic [95:0] rd_data;
    logic [7:0]  rd_id, cell_count;
    logic        wr_req, wr_grant;
    logic [7:0]  wr_addr;
    logic [95:0] wr_data;
    logic [7:0]  mem_address;
    logic [95:0] mem_data, mem_q;
    logic        mem_rden, mem_wren;

    always #5 clk = ~clk;

    pos_cell_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_rd_start(rd_start), .i_rd_abort(rd_abort),
        .o_rd_busy(rd_busy), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_rd_id(rd_id), .o_rd_done(rd_done), .o_cell_count(cell_count),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_grant(wr_grant),
        .o_mem_address(mem_address), .o_mem_data(mem_data),
        .o_mem_rden(mem_rden), .o_mem_wren(mem_wren), .i_mem_q(mem_q)
    );

    // RAM model: registered address plus registered output.
    logic [95:0] mem_arr [0:255];
    logic [95:0] q1_reg, q2_reg;
    always @(posedge clk) begin
        if (mem_wren) mem_arr[mem_address] <= mem_data;
        q1_reg <= mem_arr[mem_address];
        q2_reg <= q1_reg;
    end
    assign mem_q = q2_reg;

    int n_both;
    always @(negedge clk)
        if (rst_n && mem_rden && mem_wren) n_both++;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int q_vid[$];
    int q_vcyc[$];
    logic [95:0] q_vdat[$];
    int grant_cyc[$];
    int n_done, done_cyc, cnt_rd_cyc, n_rden_nz;

    localparam logic [95:0] DA = 96'h0000_00A1_0000_00A2_0000_00A3;
    localparam logic [95:0] DB = 96'h0000_00B1_0000_00B2_0000_00B3;
    localparam logic [95:0] DC = 96'h0000_00C1_0000_00C2_0000_00C3;

    function automatic logic [95:0] pat(input int i);
        return {32'(i * 3 + 7), 32'hCAFE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    task automatic check_value(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        q_vid.delete(); q_vcyc.delete(); q_vdat.delete(); grant_cyc.delete();
        n_done = 0; done_cyc = -1; cnt_rd_cyc = -1; n_rden_nz = 0;
    endtask

    // Sample the current cycle at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        if (rd_valid) begin
            q_vid.push_back(int'(rd_id)); q_vdat.push_back(rd_data); q_vcyc.push_back(cyc);
        end
        if (rd_done) begin n_done++; done_cyc = cyc; end
        if (mem_rden && mem_address == 8'd0 && cnt_rd_cyc < 0) cnt_rd_cyc = cyc;
        if (mem_rden && mem_address != 8'd0) n_rden_nz++;
        if (wr_grant) grant_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [95:0] d);
        int ng, k;
        ng = grant_cyc.size(); k = 0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        while (grant_cyc.size() == ng && k < 50) begin step(); k++; end
        wr_req = 1'b0;
        if (grant_cyc.size() == ng) check_value("write_grant_timeout", 0, 1);
    endtask

    task automatic pulse_read(output int p);
        clear_rec();
        p = cyc;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (n_done == 0 && k < limit) begin step(); k++; end
        check_value({tag, "_done_seen"}, n_done, 1);
    endtask

    task automatic check_stream(input string tag, input int n);
        check_value({tag, "_nvalid"}, q_vid.size(), n);
        for (int i = 0; i < q_vid.size() && i < n; i++) begin
            check_value($sformatf("%s_id%0d", tag, i + 1), q_vid[i], i + 1);
            check_value($sformatf("%s_data%0d", tag, i + 1), q_vdat[i], pat(i + 1));
            check_value($sformatf("%s_cyc%0d", tag, i + 1), q_vcyc[i] - q_vcyc[0], i);
        end
        if (q_vcyc.size() > 0)
            check_value({tag, "_done_after_last"}, done_cyc - q_vcyc[q_vcyc.size() - 1], 1);
        $display("read %s: %0d particles, cell_count=%0d", tag, q_vid.size(), cell_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, c0, c1, late;
        rst_n = 1'b0; rd_start = 1'b0; rd_abort = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clear_rec();
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_busy", rd_busy, 0);
        check_value("rst_valid", rd_valid, 0);
        check_value("rst_done", rd_done, 0);
        check_value("rst_count", cell_count, 0);
        check_value("rst_grant", wr_grant, 0);
        check_value("rst_rden", mem_rden, 0);
        check_value("rst_wren", mem_wren, 0);
        check_value("rst_addr", mem_address, 0);
        rst_n = 1'b1;
        step();

        // 1: count 3, words A,B,C
        do_write(8'd0, 96'd3); do_write(8'd1, DA); do_write(8'd2, DB); do_write(8'd3, DC);
        pulse_read(p);
        wait_done("t1", 40);
        check_value("t1_cnt_rd_cyc", cnt_rd_cyc - p, 1);
        check_value("t1_nvalid", q_vid.size(), 3);
        if (q_vid.size() == 3) begin
            check_value("t1_id1", q_vid[0], 1); check_value("t1_data1", q_vdat[0], DA);
            check_value("t1_id2", q_vid[1], 2); check_value("t1_data2", q_vdat[1], DB);
            check_value("t1_id3", q_vid[2], 3); check_value("t1_data3", q_vdat[2], DC);
            check_value("t1_first_valid_cyc", q_vcyc[0] - p, 6);
            check_value("t1_last_valid_cyc", q_vcyc[2] - p, 8);
        end
        check_value("t1_done_cyc", done_cyc - p, 9);
        check_value("t1_cell_count", cell_count, 3);
        check_value("t1_busy_after", rd_busy, 0);
        $display("read t1: %0d particles, cell_count=%0d", q_vid.size(), cell_count);

        // 2: empty cell
        do_write(8'd0, 96'd0);
        pulse_read(p);
        wait_done("t2", 40);
        check_value("t2_nvalid", q_vid.size(), 0);
        check_value("t2_rden_nonzero", n_rden_nz, 0);
        check_value("t2_done_cyc", done_cyc - p, 4);
        check_value("t2_cell_count", cell_count, 0);
        $display("read t2: %0d particles, cell_count=%0d", q_vid.size(), cell_count);

        // 3: collision right after reset, write to count wins
        rst_n = 1'b0; #2; rst_n = 1'b1;
        clear_rec();
        c0 = cyc;
        wr_req = 1'b1; wr_addr = 8'd0; wr_data = 96'd2; rd_start = 1'b1;
        step();
        wr_req = 1'b0; rd_start = 1'b0;
        check_value("t3_grant_count", grant_cyc.size(), 1);
        if (grant_cyc.size() > 0) check_value("t3_grant_cyc", grant_cyc[0] - c0, 0);
        wait_done("t3", 40);
        check_value("t3_cnt_rd_cyc", cnt_rd_cyc - c0, 2);
        check_value("t3_nvalid", q_vid.size(), 2);
        if (q_vid.size() == 2) begin
            check_value("t3_data1", q_vdat[0], DA);
            check_value("t3_data2", q_vdat[1], DB);
        end
        check_value("t3_done_cyc", done_cyc - c0, 9);
        $display("read t3: %0d particles, cell_count=%0d", q_vid.size(), cell_count);
        clear_rec();
        c1 = cyc;
        wr_req = 1'b1; wr_addr = 8'd5; wr_data = pat(5); rd_start = 1'b1;
        step();
        wr_req = 1'b0; rd_start = 1'b0;
        check_value("t3b_grant_count", grant_cyc.size(), 1);
        if (grant_cyc.size() > 0) check_value("t3b_grant_cyc", grant_cyc[0] - c1, 0);
        wait_done("t3b", 40);
        check_value("t3b_cnt_rd_cyc", cnt_rd_cyc - c1, 2);
        check_value("t3b_nvalid", q_vid.size(), 2);

        // Preload position words 1..219
        for (int i = 1; i < 220; i++) do_write(8'(i), pat(i));

        // 4: write held during a 10-particle stream
        do_write(8'd0, 96'd10);
        pulse_read(p);
        while (cyc < p + 5) step();
        wr_req = 1'b1; wr_addr = 8'd200; wr_data = pat(200);
        wait_done("t4", 60);
        check_value("t4_no_grant_during_read", grant_cyc.size(), 0);
        step();
        wr_req = 1'b0;
        check_value("t4_grant_count", grant_cyc.size(), 1);
        if (grant_cyc.size() > 0) check_value("t4_grant_after_done", grant_cyc[0] - done_cyc, 1);
        check_stream("t4", 10);

        // 5: count 255 clamps to 219
        do_write(8'd0, 96'd255);
        pulse_read(p);
        wait_done("t5", 300);
        check_value("t5_cell_count", cell_count, 219);
        check_stream("t5", 219);

        // 6: abort on the third stream cycle, then a normal read
        do_write(8'd0, 96'd6);
        pulse_read(p);
        while (cyc < p + 6) step();
        rd_abort = 1'b1;
        step();
        rd_abort = 1'b0;
        repeat (12) step();
        late = 0;
        foreach (q_vcyc[i]) if (q_vcyc[i] > p + 6) late++;
        check_value("t6_no_valid_after_abort", late, 0);
        check_value("t6_no_done", n_done, 0);
        check_value("t6_busy_after_abort", rd_busy, 0);
        check_value("t6_count_kept", cell_count, 6);
        pulse_read(p);
        wait_done("t6b", 40);
        check_stream("t6b", 6);

        // Asynchronous reset mid-stream with a write pending
        pulse_read(p);
        while (cyc < p + 7) step();
        check_value("t6_pre_rst_valid", rd_valid, 1);
        wr_req = 1'b1; wr_addr = 8'd9; wr_data = pat(9);
        #2 rst_n = 1'b0;
        #1;
        check_value("t6_rst_busy", rd_busy, 0);
        check_value("t6_rst_valid", rd_valid, 0);
        check_value("t6_rst_data", rd_data, 0);
        check_value("t6_rst_id", rd_id, 0);
        check_value("t6_rst_done", rd_done, 0);
        check_value("t6_rst_count", cell_count, 0);
        check_value("t6_rst_grant", wr_grant, 0);
        check_value("t6_rst_wren", mem_wren, 0);
        check_value("t6_rst_rden", mem_rden, 0);
        check_value("t6_rst_addr", mem_address, 0);
        check_value("t6_rst_mdata", mem_data, 0);
        wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        check_value("rden_wren_exclusive", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pos_cell_access_ctrl.md
Name: pos_cell_access_ctrl

Overview:
Sequencer and arbiter in front of one single-port cell position memory, i.e. one M20K cell RAM with 2-cycle read latency. Address 0 of that memory holds the cell's particle count; addresses 1..N hold {posz, posy, posx}. The block arbitrates between two requesters:
- the force-evaluation read streamer: one start pulse reads the count, then streams every particle with an index tag;
- the motion-update writer: single-word write requests.
It sits between Pos_Cache and the cell memory instance.

Parameters:
DATA_WIDTH, 96, width of one position word {posz,posy,posx}
ADDR_WIDTH, 8, memory address width
PARTICLE_NUM, 220, memory depth; the largest legal count is PARTICLE_NUM-1
READ_LATENCY, 2, cycles from mem_address/mem_rden to valid mem_q

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_start  in  1  one-cycle pulse: request a full cell read
rd_abort  in  1  cancel the read in progress
rd_busy  out  1  read sequence pending or active
rd_valid  out  1  rd_data/rd_id valid this cycle
rd_data  out  DATA_WIDTH  particle position
rd_id  out  ADDR_WIDTH  particle address (1..count)
rd_done  out  1  one-cycle pulse after the last rd_valid
cell_count  out  ADDR_WIDTH  last count read (clamped)
wr_req  in  1  write request (level, held until granted)
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_grant  out  1  write performed this cycle
mem_address  out  ADDR_WIDTH  to memory
mem_data  out  DATA_WIDTH  to memory
mem_rden  out  1  to memory
mem_wren  out  1  to memory
mem_q  in  DATA_WIDTH  from memory

Behaviour:

Reset:
- All outputs are 0; FSM goes to IDLE; rd_pend=0; last_grant=READ; the valid/id pipeline is cleared.

rd_start handling:
- A rd_start pulse sets rd_pend.
- rd_start while rd_busy=1 is ignored.
- rd_busy = rd_pend | (state != IDLE).

Memory outputs:
- mem_* outputs are combinational from FSM state and inputs; memory registers are inside the RAM.
- mem_rden and mem_wren are never both 1.

FSM states: IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE.

IDLE:
- wr_req && !rd_pend -> grant write.
- rd_pend && !wr_req -> go to CNT_RD.
- Both asserted -> grant the requester opposite to last_grant.
- A write grant drives mem_wren=1, mem_address=wr_addr, mem_data=wr_data and wr_grant=1 in that same cycle, and sets last_grant=WRITE.

CNT_RD:
- mem_address=0, mem_rden=1; clears rd_pend; last_grant=READ.

CNT_WAIT:
- Waits READ_LATENCY cycles with a counter.
- On the final wait cycle, latches cell_count = min(mem_q[ADDR_WIDTH-1:0], PARTICLE_NUM-1) and loads the address counter with 1.
- Count 0 -> go to DONE. Otherwise -> STREAM.

STREAM:
- Each cycle: mem_address=addr_cnt, mem_rden=1; push valid=1 and id=addr_cnt into the pipeline; addr_cnt++.
- After issuing addr_cnt==cell_count -> DRAIN.
- Writes are not granted; wr_grant=0 and wr_req waits.

Pipeline output:
- READ_LATENCY stages; stage output gives rd_valid/rd_id.
- rd_data = mem_q when rd_valid=1, else 0.
- Throughput is one particle per cycle. rd_valid for id k occurs exactly READ_LATENCY cycles after its issue.

DRAIN:
- Waits until the pipeline is empty, then -> DONE.

DONE:
- rd_done=1 for one cycle, then -> IDLE.
- The write arbitration stage sees last_grant=READ, so a waiting write wins next.

rd_abort (any read state):
- Next state IDLE; pipeline valids cleared; rd_pend cleared; no rd_done; cell_count keeps its value.
- rd_abort in IDLE also clears rd_pend.

Boundaries:
- A write to address 0 updates the count. It does not affect a stream already in progress, because the count is latched.
- A stored count ≥ PARTICLE_NUM is clamped to PARTICLE_NUM-1.
- Async reset mid-stream drops all in-flight data immediately.

Test Plan:
1. Memory model has addr0=3, addr1..3=A,B,C; pulse rd_start -> CNT_RD 1 cycle after the pulse; rd_valid on 3 consecutive cycles with (id,data)=(1,A),(2,B),(3,C); rd_done 1 cycle after the last valid; cell_count=3.
2. addr0=0 -> rd_start yields rd_done with no rd_valid; mem_rden is asserted only for address 0.
3. wr_req and rd_start arrive together in IDLE after reset -> write granted first (last_grant=READ), read starts next cycle. A second read-vs-write collision after DONE -> write wins.
4. wr_req held during a STREAM of 10 particles -> wr_grant stays 0 until the cycle after rd_done; mem_wren and mem_rden are never both high.
5. addr0=255 with PARTICLE_NUM=220 -> cell_count=219; ids 1..219 are emitted in order.
6. rd_abort on the 3rd STREAM cycle of a 6-particle read -> no rd_valid after the abort cycle and no rd_done. A subsequent rd_start completes normally. rst_n low mid-stream -> all outputs 0 asynchronously.
